// File: rtl/four_phase_receiver.sv
// Purpose: receiving end of a four-phase req/ack link; queues captured words in a FIFO and drains them over valid/ready.
// Latency: word is written and ack/valid rise one edge after req_s rises (req_s = req delayed by SYNC_STAGES flops).
// Backpressure: ack is withheld while the FIFO holds DEPTH words, so a full FIFO stalls the sender via the handshake.
//
// Ports:
//   clk, reset         sole clock; synchronous active-high reset
//   req, data_in       four-phase request and its payload (payload stable while req = 1)
//   ack                registered four-phase acknowledge, high exactly in ACKED
//   data_out, valid    head-of-FIFO word (0 when empty) and FIFO non-empty flag
//   ready              downstream accepts data_out this cycle
//   count              registered FIFO occupancy
module four_phase_receiver #(
  parameter int DATA_WIDTH  = 4,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req,
  input  logic [DATA_WIDTH-1:0]        data_in,
  output logic                         ack,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         valid,
  input  logic                         ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {
    IDLE  = 1'b0,
    ACKED = 1'b1
  } state_t;

  logic req_s;

  // Optional synchroniser chain on req; depth 0 feeds req straight to the FSM.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign req_s = req;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      logic [SYNC_STAGES-1:0] sync_d;

      always_comb begin
        sync_d    = sync_q;
        sync_d[0] = req;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          sync_d[i] = sync_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          sync_q <= '0;
        end else begin
          sync_q <= sync_d;
        end
      end

      assign req_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  state_t                 state_q, state_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

  logic wr_en;
  logic rd_en;

  // A write happens only on the IDLE->ACKED edge, so a long-held req writes
  // once. The full check uses the registered count: a same-cycle read does
  // not open a slot for the write.
  assign wr_en = (state_q == IDLE) && req_s && (count_q != FULL);
  assign rd_en = (count_q != '0) && ready;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    case (state_q)
      IDLE:    if (wr_en)  state_d = ACKED;
      ACKED:   if (!req_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;

    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; the pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign ack      = (state_q == ACKED);
  assign count    = count_q;
  assign valid    = (count_q != '0);
  assign data_out = valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_four_phase_receiver.sv
module tb_four_phase_receiver;

  logic       clk;
  logic       reset;

  // DUT with direct req sampling
  logic       req;
  logic [3:0] data_in;
  logic       ack;
  logic [3:0] data_out;
  logic       valid;
  logic       ready;
  logic [2:0] count;

  // DUT with a two-flop req synchroniser
  logic       req2;
  logic [3:0] data_in2;
  logic       ack2;
  logic [3:0] data_out2;
  logic       valid2;
  logic       ready2;
  logic [2:0] count2;

  int checks;
  int errors;

  logic [3:0] exp_q[$];

  four_phase_receiver #(.DATA_WIDTH(4), .DEPTH(4), .SYNC_STAGES(0)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .data_in  (data_in),
    .ack      (ack),
    .data_out (data_out),
    .valid    (valid),
    .ready    (ready),
    .count    (count)
  );

  four_phase_receiver #(.DATA_WIDTH(4), .DEPTH(4), .SYNC_STAGES(2)) dut2 (
    .clk      (clk),
    .reset    (reset),
    .req      (req2),
    .data_in  (data_in2),
    .ack      (ack2),
    .data_out (data_out2),
    .valid    (valid2),
    .ready    (ready2),
    .count    (count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one rising edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full four-phase transaction on the SYNC_STAGES=0 DUT with bounded waits.
  task automatic send(input logic [3:0] d);
    int n;
    data_in = d;
    req     = 1'b1;
    exp_q.push_back(d);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ack && n < 50);
    chk("send_ack_rise", ack, 1);
    req = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (ack && n < 50);
    chk("send_ack_fall", ack, 0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    req      = 1'b0;
    data_in  = '0;
    ready    = 1'b0;
    req2     = 1'b0;
    data_in2 = '0;
    ready2   = 1'b1;

    fork
      // Scoreboard monitor: pops and compares whenever a word is accepted.
      begin
        forever begin
          @(negedge clk);
          if (!reset && valid && ready) begin
            if (exp_q.size() == 0) begin
              chk("mon_unexpected_word", data_out, 4'hx);
            end else begin
              chk("mon_data_out", data_out, exp_q.pop_front());
            end
          end
        end
      end

      begin
        tick();
        tick();
        reset = 1'b0;
        chk("rst_ack", ack, 0);
        chk("rst_valid", valid, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_count", count, 0);

        // Single transfer, ready=1: ack one edge after req, valid pulses with F.
        ready   = 1'b1;
        data_in = 4'hF;
        req     = 1'b1;
        exp_q.push_back(4'hF);
        tick();
        chk("s1_ack_rise", ack, 1);
        chk("s1_valid", valid, 1);
        chk("s1_count1", count, 1);
        req = 1'b0;
        tick();
        chk("s1_ack_fall", ack, 0);
        chk("s1_count0", count, 0);
        ready = 1'b0;

        // Two transfers queued, then drained on consecutive cycles.
        send(4'hF);
        send(4'hA);
        chk("s2_count2", count, 2);
        chk("s2_head", data_out, 4'hF);
        ready = 1'b1;
        tick();
        chk("s2_next_head", data_out, 4'hA);
        tick();
        chk("s2_count0", count, 0);
        ready = 1'b0;

        // Overfill: fifth request stalls until a slot opens.
        send(4'h1);
        send(4'h2);
        send(4'h3);
        send(4'h4);
        chk("s3_full", count, 4);
        data_in = 4'h5;
        req     = 1'b1;
        exp_q.push_back(4'h5);
        tick();
        tick();
        tick();
        chk("s3_stall_ack", ack, 0);
        chk("s3_stall_count", count, 4);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("s3_no_fallthrough_ack", ack, 0);
        chk("s3_after_read_count", count, 3);
        tick();
        chk("s3_late_ack", ack, 1);
        chk("s3_refull", count, 4);
        req = 1'b0;
        tick();
        ready = 1'b1;
        repeat (4) tick();
        ready = 1'b0;
        chk("s3_drained", count, 0);

        // req held for 10 cycles: one write, data changes in ACKED ignored.
        data_in = 4'h7;
        req     = 1'b1;
        exp_q.push_back(4'h7);
        for (int i = 0; i < 10; i++) begin
          tick();
          data_in = 4'h9;
          chk("s4_ack_held", ack, 1);
        end
        chk("s4_one_write", count, 1);
        req = 1'b0;
        tick();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("s4_drained", count, 0);

        // Reset in ACKED with 3 entries, req still high: recapture after release.
        send(4'h1);
        send(4'h2);
        data_in = 4'h3;
        req     = 1'b1;
        tick();
        chk("s5_acked", ack, 1);
        chk("s5_count3", count, 3);
        reset = 1'b1;
        exp_q.delete();
        tick();
        chk("s5_rst_ack", ack, 0);
        chk("s5_rst_count", count, 0);
        chk("s5_rst_valid", valid, 0);
        reset = 1'b0;
        exp_q.push_back(4'h3);
        tick();
        chk("s5_recap_ack", ack, 1);
        chk("s5_recap_count", count, 1);
        req = 1'b0;
        tick();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("s5_drained", count, 0);

        // Two sync stages: ack rises and falls 3 edges after the req edge.
        data_in2 = 4'hF;
        req2     = 1'b1;
        tick();
        tick();
        chk("s6_ack_not_yet", ack2, 0);
        tick();
        chk("s6_ack_rise", ack2, 1);
        chk("s6_valid", valid2, 1);
        chk("s6_data", data_out2, 4'hF);
        req2 = 1'b0;
        tick();
        tick();
        chk("s6_ack_still", ack2, 1);
        tick();
        chk("s6_ack_fall", ack2, 0);
        chk("s6_count", count2, 0);

        tick();
        chk("sb_empty", exp_q.size(), 0);
      end
    join_any
    disable fork;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
